div_unit: RTL
=============

# div_unit

Iterative 32-bit integer divider for the execute stage, implementing MIPS DIV/DIVU semantics. It sits directly upstream of the HI/LO `register` instances. `out_quotient` feeds LO, `out_remainder` feeds HI, and `out_done` drives both registers' `in_wena`. Operands come from the ID/EX operand bus. The result is produced a fixed 33 cycles after acceptance, so the pipeline controller can stall on `out_busy`.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- Clocking and reset: one clock, `in_clk`. Reset `in_rst` is synchronous and active-high.
- `in_clk` input 1: clock; all state updates on the rising edge.
- `in_rst` input 1: synchronous active-high reset.
- `in_start` input 1: request a division; sampled only in IDLE.
- `in_signed` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `in_dividend` input 32: dividend (rs).
- `in_divisor` input 32: divisor (rt).
- `out_busy` output 1: high while a division is in progress.
- `out_done` output 1: one-cycle pulse when results are valid; serves as HI/LO write enable.
- `out_quotient` output 32: quotient, destined for LO.
- `out_remainder` output 32: remainder, destined for HI.

## Operation
- States:
  - IDLE: `out_busy`=0.
  - CALC: `out_busy`=1, 32 iterations.
  - FIX: `out_busy`=1, one cycle.
- Acceptance, in IDLE with `in_start`=1:
  - latch the magnitudes of the operands (|x| when `in_signed`=1 and x[31]=1, else x);
  - latch the quotient sign (`in_signed` & (dividend[31]^divisor[31])) and the remainder sign (`in_signed` & dividend[31]);
  - clear the 33-bit partial remainder and the 6-bit counter; go to CALC.
- CALC step, restoring:
  - shift the {partial remainder, dividend magnitude} pair left by 1;
  - trial-subtract the divisor magnitude (33-bit);
  - if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0;
  - increment the counter; after the 32nd step go to FIX.
- FIX:
  - negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set;
  - register both onto the outputs, set `out_done`=1, go to IDLE.
- In IDLE, `out_done` clears on the next edge.
- Result semantics:
  - the quotient truncates toward zero;
  - the remainder takes the sign of the dividend;
  - |dividend| is treated as a 32-bit unsigned value, so 0x80000000 is handled.
- Overflow, signed 0x80000000 / 0xFFFFFFFF: Q=0x80000000, R=0. This is the natural result; no special case.
- Divide by zero, same latency, no exception:
  - unsigned: Q=0xFFFFFFFF, R=dividend;
  - signed: Q = 0x00000001 if dividend < 0, else 0xFFFFFFFF; R=dividend.
- `out_quotient` and `out_remainder` hold their last result until the next FIX. They never change during CALC.
- `in_start` while busy is ignored and not queued.
- Operand inputs may change after acceptance without effect.

## Timing
- Reset, applied at an edge with `in_rst`=1:
  - state=IDLE, `out_busy`=0, `out_done`=0, `out_quotient`=0, `out_remainder`=0;
  - internal counter and partial remainder cleared.
- Reset mid-operation aborts the division: no `out_done`, outputs forced to 0.
- Reset has priority over `in_start` at the same edge.
- Latency, with the start accepted at edge E0:
  - CALC runs E1..E32;
  - FIX executes at E33;
  - `out_busy` is high from just after E0 to just after E33;
  - `out_done` is high for exactly the one cycle between E33 and E34;
  - results are valid from E33 onward.
- Back-to-back: `in_start` in the `out_done` cycle (state IDLE) is accepted at E34. `out_done` still falls at E34. Outputs keep the old result until the new FIX.
- The downstream HI/LO registers capture on the falling edge inside the `out_done` cycle. Results are therefore stable for half a cycle before capture; no extra alignment is required.

## Test plan
- Reset: assert `in_rst` for 2 cycles → all outputs 0. Then unsigned 100 / 7 with start at E0 → `out_busy` high E0–E33; `out_done` pulse E33–E34; Q=14, R=2.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → Q=0xFFFFFFFD, R=0xFFFFFFFF. Signed 7 / −2 → Q=0xFFFFFFFD, R=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → Q=0x80000000, R=0. Unsigned 0xFFFFFFFF / 0x10 → Q=0x0FFFFFFF, R=0xF.
- Divide by zero:
  - unsigned 5 / 0 → Q=0xFFFFFFFF, R=5;
  - signed −5 / 0 → Q=0x00000001, R=0xFFFFFFFB;
  - in both cases `out_done` arrives at E33.
- Start 100 / 7, then pulse `in_start` with 9 / 3 at E5 → ignored; result stays Q=14, R=2.
- Start 100 / 7, then assert `in_rst` at E10 → `out_busy`=0 and outputs 0 after E10, and no `out_done` ever appears.
- Start 100 / 7, then present `in_start` with 20 / 6 in the `out_done` cycle → second result Q=3, R=2 with `out_done` at E34+33.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring 32-bit divider with MIPS DIV/DIVU semantics.
// Accepts in IDLE, runs 32 CALC steps, fixes signs in FIX; result valid 33 cycles after acceptance.
module div_unit (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_start,
    input  logic        in_signed,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    output logic        out_busy,
    output logic        out_done,
    output logic [31:0] out_quotient,
    output logic [31:0] out_remainder
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            accept;
    logic            last_step;
    logic            busy_nx;
    logic            done_nx;

    logic [DW:0]     prem;
    logic [DW-1:0]   quo;
    logic [DW-1:0]   dvsr;
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;

    logic [DW+1:0]   trial;
    logic [DW-1:0]   dvnd_mag;
    logic [DW-1:0]   dvsr_mag;
    logic [DW-1:0]   q_fixed;
    logic [DW-1:0]   r_fixed;

    assign accept    = (state == IDLE) && in_start;
    assign last_step = (cnt == CW'(DW - 1));

    // State register
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_start)  state_nx = CALC;
            CALC:    if (last_step) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered status outputs
    always_comb begin
        busy_nx = 1'b0;
        done_nx = 1'b0;
        if (state_nx != IDLE) busy_nx = 1'b1;
        if (state == FIX)     done_nx = 1'b1;
    end

    // Operand magnitudes, trial subtraction and sign fix-up
    always_comb begin
        dvnd_mag = in_dividend;
        dvsr_mag = in_divisor;
        if (in_signed && in_dividend[DW-1]) dvnd_mag = ~in_dividend + DW'(1);
        if (in_signed && in_divisor[DW-1])  dvsr_mag = ~in_divisor + DW'(1);
        trial   = {prem, quo[DW-1]} - {2'b00, dvsr};
        q_fixed = q_neg ? (~quo + DW'(1)) : quo;
        r_fixed = r_neg ? (~prem[DW-1:0] + DW'(1)) : prem[DW-1:0];
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            prem          <= '0;
            quo           <= '0;
            dvsr          <= '0;
            cnt           <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            out_busy      <= 1'b0;
            out_done      <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
        end else begin
            out_busy <= busy_nx;
            out_done <= done_nx;
            if (accept) begin
                prem  <= '0;
                cnt   <= '0;
                quo   <= dvnd_mag;
                dvsr  <= dvsr_mag;
                q_neg <= in_signed & (in_dividend[DW-1] ^ in_divisor[DW-1]);
                r_neg <= in_signed & in_dividend[DW-1];
            end else if (state == CALC) begin
                // Non-negative trial keeps the difference and shifts in a 1
                if (!trial[DW+1]) begin
                    prem <= trial[DW:0];
                    quo  <= {quo[DW-2:0], 1'b1};
                end else begin
                    prem <= {prem[DW-1:0], quo[DW-1]};
                    quo  <= {quo[DW-2:0], 1'b0};
                end
                cnt <= cnt + CW'(1);
            end else if (state == FIX) begin
                out_quotient  <= q_fixed;
                out_remainder <= r_fixed;
            end
        end
    end
endmodule
